// File: rtl/cve2_mem_arbiter.sv
// cve2_mem_arbiter
// Merges the instruction-fetch and data ports of the core onto one memory
// port. Fixed-priority arbitration with a starvation limit, a lock that keeps
// an ungranted request stable, and an in-order source-ID FIFO that routes
// each response back to the port that issued it.

module cve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic        unexp_rvalid_o
);

  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  localparam logic [CntW-1:0]    MaxCnt    = CntW'(MaxOutstanding);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);
  localparam logic               FavData   = DataPriority;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e              state_r, state_nxt_s;
  logic                     lock_src_r, lock_src_nxt_s;
  logic [StarveW-1:0]       starve_r, starve_nxt_s;
  logic [MaxOutstanding-1:0] ids_r, ids_nxt_s;
  logic [CntW-1:0]          cnt_r, cnt_nxt_s, wr_idx_s;
  logic                     unexp_r;

  logic sel_data_s;
  logic sel_req_s;
  logic both_req_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic mem_req_s;
  logic hs_s;
  logic pop_s;
  logic push_s;
  logic head_s;

  assign both_req_s   = instr_req_i & data_req_i;
  assign fifo_full_s  = (cnt_r == MaxCnt);
  assign fifo_empty_s = (cnt_r == CntW'(0));
  assign head_s       = ids_r[0];

  // Pick the source: a locked source wins, then a lone requester, then the tie rule.
  always_comb begin
    sel_data_s = 1'b0;
    if (state_r == ST_LOCKED) begin
      sel_data_s = lock_src_r;
    end else if (both_req_s) begin
      sel_data_s = (starve_r == StarveMax) ? ~FavData : FavData;
    end else if (data_req_i) begin
      sel_data_s = 1'b1;
    end else begin
      sel_data_s = 1'b0;
    end
  end

  assign sel_req_s = sel_data_s ? data_req_i : instr_req_i;
  assign mem_req_s = sel_req_s & ~fifo_full_s;
  assign hs_s      = mem_req_s & mem_gnt_i;
  assign push_s    = hs_s;
  assign pop_s     = mem_rvalid_i & ~fifo_empty_s;

  // Request side: payload follows the selected source; instruction fetches read full words.
  assign mem_req_o   = mem_req_s;
  assign mem_we_o    = sel_data_s ? data_we_i    : 1'b0;
  assign mem_be_o    = sel_data_s ? data_be_i    : 4'hF;
  assign mem_addr_o  = sel_data_s ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = sel_data_s ? data_wdata_i : 32'h0000_0000;

  assign instr_gnt_o = hs_s & ~sel_data_s;
  assign data_gnt_o  = hs_s &  sel_data_s;

  // Response side: the FIFO head names the owner of the returning beat.
  assign instr_rvalid_o = pop_s & ~head_s;
  assign data_rvalid_o  = pop_s &  head_s;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

  assign unexp_rvalid_o = unexp_r;

  // Lock next-state: hold the source while its request waits for a grant.
  always_comb begin
    state_nxt_s    = state_r;
    lock_src_nxt_s = lock_src_r;
    case (state_r)
      ST_UNLOCKED: begin
        if (mem_req_s && !mem_gnt_i) begin
          state_nxt_s    = ST_LOCKED;
          lock_src_nxt_s = sel_data_s;
        end else begin
          state_nxt_s    = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        // A dropped request would otherwise wedge the arbiter on a dead source.
        if (hs_s || !sel_req_s) begin
          state_nxt_s = ST_UNLOCKED;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s    = ST_UNLOCKED;
        lock_src_nxt_s = 1'b0;
      end
    endcase
  end

  // Starvation counter: counts contested wins of the favoured port, cleared when the other wins.
  always_comb begin
    starve_nxt_s = starve_r;
    if (hs_s) begin
      if (sel_data_s != FavData) begin
        starve_nxt_s = StarveW'(0);
      end else if (both_req_s && (starve_r != StarveMax)) begin
        starve_nxt_s = starve_r + StarveW'(1);
      end else begin
        starve_nxt_s = starve_r;
      end
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // ID FIFO next-state: pop shifts toward the head, push writes just past the last valid entry.
  always_comb begin
    ids_nxt_s = ids_r;
    cnt_nxt_s = cnt_r;
    wr_idx_s  = cnt_r;
    if (pop_s) begin
      ids_nxt_s = ids_r >> 1;
      wr_idx_s  = cnt_r - CntW'(1);
    end else begin
      ids_nxt_s = ids_r;
      wr_idx_s  = cnt_r;
    end
    if (push_s) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        if (CntW'(i) == wr_idx_s) begin
          ids_nxt_s[i] = sel_data_s;
        end else begin
          ids_nxt_s[i] = ids_nxt_s[i];
        end
      end
    end else begin
      ids_nxt_s = ids_nxt_s;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CntW'(1);
      2'b01:   cnt_nxt_s = cnt_r - CntW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // State registers for the lock, starvation counter and ID FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_UNLOCKED;
      lock_src_r <= 1'b0;
      starve_r   <= StarveW'(0);
      ids_r      <= {MaxOutstanding{1'b0}};
      cnt_r      <= CntW'(0);
    end else begin
      state_r    <= state_nxt_s;
      lock_src_r <= lock_src_nxt_s;
      starve_r   <= starve_nxt_s;
      ids_r      <= ids_nxt_s;
      cnt_r      <= cnt_nxt_s;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unexp_r <= 1'b0;
    end else if (mem_rvalid_i && fifo_empty_s) begin
      unexp_r <= 1'b1;
    end else begin
      unexp_r <= unexp_r;
    end
  end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Randomized and directed bench for cve2_mem_arbiter against a transaction-level model.

module tb_cve2_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int FAV   = 1;  // data favoured
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req = 1'b0;
  logic        instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr = 32'h0;
  logic [31:0] instr_rdata;
  logic        data_req = 1'b0;
  logic        data_gnt, data_rvalid, data_err;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;
  logic        unexp_rvalid;

  always #5 clk = ~clk;

  cve2_mem_arbiter #(
    .MaxOutstanding(DEPTH),
    .DataPriority  (1'b1),
    .StarveLimit   (LIMIT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .instr_req_i   (instr_req),
    .instr_gnt_o   (instr_gnt),
    .instr_rvalid_o(instr_rvalid),
    .instr_addr_i  (instr_addr),
    .instr_rdata_o (instr_rdata),
    .instr_err_o   (instr_err),
    .data_req_i    (data_req),
    .data_gnt_o    (data_gnt),
    .data_rvalid_o (data_rvalid),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_rdata_o  (data_rdata),
    .data_err_o    (data_err),
    .mem_req_o     (mem_req),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_we_o      (mem_we),
    .mem_be_o      (mem_be),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_err_i     (mem_err),
    .unexp_rvalid_o(unexp_rvalid)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference state
  int src_q[$];    // sources of accepted, unanswered transactions (0=I, 1=D)
  int pend;        // source whose offered request is still waiting, -1 if none
  int starve;      // contested wins of the favoured port since the other port won
  bit unexp_m;
  bit e_req, e_ig, e_dg, e_irv, e_drv;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle, compare DUT against the model for this cycle, then advance the model past the edge.
  task automatic model_cycle();
    int sel;
    bit sel_req, full, pop, other_req;
    #1;
    if (pend >= 0)                    sel = pend;
    else if (instr_req && !data_req)  sel = 0;
    else if (data_req && !instr_req)  sel = 1;
    else if (instr_req && data_req)   sel = (starve == LIMIT) ? 1 - FAV : FAV;
    else                              sel = 0;
    sel_req = (sel == 1) ? data_req : instr_req;
    full    = (src_q.size() >= DEPTH);
    e_req   = sel_req && !full;
    e_ig    = e_req && mem_gnt && (sel == 0);
    e_dg    = e_req && mem_gnt && (sel == 1);
    pop     = mem_rvalid && (src_q.size() > 0);
    e_irv   = 1'b0;
    e_drv   = 1'b0;
    if (pop) begin
      e_irv = (src_q[0] == 0);
      e_drv = (src_q[0] == 1);
    end
    check_val("mem_req", 32'(mem_req), 32'(e_req));
    check_val("instr_gnt", 32'(instr_gnt), 32'(e_ig));
    check_val("data_gnt", 32'(data_gnt), 32'(e_dg));
    check_val("instr_rvalid", 32'(instr_rvalid), 32'(e_irv));
    check_val("data_rvalid", 32'(data_rvalid), 32'(e_drv));
    check_val("instr_rdata", instr_rdata, mem_rdata);
    check_val("data_rdata", data_rdata, mem_rdata);
    check_val("instr_err", 32'(instr_err), 32'(mem_err));
    check_val("data_err", 32'(data_err), 32'(mem_err));
    check_val("unexp", 32'(unexp_rvalid), 32'(unexp_m));
    if (e_req) begin
      check_val("mem_addr", mem_addr, (sel == 1) ? data_addr : instr_addr);
      check_val("mem_we", 32'(mem_we), (sel == 1) ? 32'(data_we) : 32'd0);
      check_val("mem_be", 32'(mem_be), (sel == 1) ? 32'(data_be) : 32'hF);
      check_val("mem_wdata", mem_wdata, (sel == 1) ? data_wdata : 32'd0);
    end
    if (mem_rvalid && src_q.size() == 0) unexp_m = 1'b1;
    if (pop) void'(src_q.pop_front());
    if (e_req && mem_gnt) begin
      src_q.push_back(sel);
      other_req = (sel == 1) ? instr_req : data_req;
      if (sel == FAV) begin
        if (other_req && starve < LIMIT) starve++;
      end else begin
        starve = 0;
      end
      pend = -1;
    end else if (e_req) begin
      pend = sel;
    end
  endtask

  task automatic tick();
    model_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    #1;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_gnt", 32'({instr_gnt, data_gnt}), 32'd0);
    check_val("rst_rvalid", 32'({instr_rvalid, data_rvalid}), 32'd0);
    check_val("rst_unexp", 32'(unexp_rvalid), 32'd0);
    src_q.delete();
    pend = -1;
    starve = 0;
    unexp_m = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    pend = -1;
    starve = 0;
    unexp_m = 1'b0;
    @(negedge clk);
    do_reset();

    // Single fetch
    instr_req = 1'b1; instr_addr = 32'h80; mem_gnt = 1'b1;
    model_cycle();
    check_val("fetch_gnt", 32'(instr_gnt), 32'd1);
    @(negedge clk);
    instr_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    model_cycle();
    check_val("fetch_rvalid", 32'({instr_rvalid, data_rvalid}), 32'b10);
    check_val("fetch_rdata", instr_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Tie: data favoured, instr gets every fifth grant
    do_reset();
    instr_req = 1'b1; instr_addr = 32'h40;
    data_req = 1'b1; data_addr = 32'h400; data_we = 1'b1; data_be = 4'h3; data_wdata = 32'h1234_5678;
    mem_gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mem_rvalid = (k > 0);
      model_cycle();
      check_val("tie_dgnt", 32'(data_gnt), (k % 5 != 4) ? 32'd1 : 32'd0);
      check_val("tie_ignt", 32'(instr_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
      if (k % 5 == 4) check_val("tie_i_be_we", 32'({mem_be, mem_we}), 32'b11110);
      @(negedge clk);
    end

    // Stall lock: late data request must not steal the pending instr slot
    do_reset();
    instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b0;
    tick();
    data_req = 1'b1; data_addr = 32'h200; data_be = 4'hF;
    model_cycle();
    check_val("lock_addr", mem_addr, 32'h100);
    @(negedge clk);
    tick();
    mem_gnt = 1'b1;
    model_cycle();
    check_val("lock_first_gnt", 32'({instr_gnt, data_gnt}), 32'b10);
    @(negedge clk);
    instr_req = 1'b0;
    tick();
    data_req = 1'b0; mem_gnt = 1'b0;

    // Full FIFO and response ordering with a faulting store
    do_reset();
    instr_req = 1'b1; instr_addr = 32'h10; mem_gnt = 1'b1;
    tick();
    instr_req = 1'b0; data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20; data_be = 4'hC;
    tick();
    data_req = 1'b0; instr_req = 1'b1; instr_addr = 32'h30;
    model_cycle();
    check_val("full_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
    model_cycle();
    check_val("full_pop_irv", 32'(instr_rvalid), 32'd1);
    check_val("full_pop_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h0;
    model_cycle();
    check_val("reissue_gnt", 32'(instr_gnt), 32'd1);
    check_val("store_err", 32'({instr_rvalid, data_rvalid, data_err}), 32'b011);
    @(negedge clk);
    instr_req = 1'b0; mem_gnt = 1'b0; mem_err = 1'b0;
    tick();
    mem_rvalid = 1'b0;

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!instr_req && $urandom_range(0, 2) != 0) begin
        instr_req = 1'b1;
        instr_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(0, 2) != 0) begin
        data_req = 1'b1;
        data_addr = $urandom();
        data_we = 1'($urandom_range(0, 1));
        data_be = 4'($urandom_range(1, 15));
        data_wdata = $urandom();
      end
      mem_gnt = 1'($urandom_range(0, 1));
      mem_rvalid = (src_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom();
      mem_err = ($urandom_range(0, 7) == 0);
      tick();
      if (e_ig) instr_req = 1'b0;
      if (e_dg) data_req = 1'b0;
    end

    // Stray response, then a reset with a transaction in flight
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'h5;
    tick();
    mem_rvalid = 1'b0;
    model_cycle();
    check_val("stray_unexp", 32'(unexp_rvalid), 32'd1);
    @(negedge clk);
    tick();
    do_reset();
    instr_req = 1'b1; instr_addr = 32'h44; mem_gnt = 1'b1;
    tick();
    do_reset();
    mem_rvalid = 1'b1;
    model_cycle();
    check_val("late_rvalid", 32'({instr_rvalid, data_rvalid}), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    model_cycle();
    check_val("late_unexp", 32'(unexp_rvalid), 32'd1);
    @(negedge clk);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
